pipe_seg_buf: RTL and testbench

Parametrised, elastic successor to the fixed inter-stage segment registers. It carries an opaque packed payload of DW bits between two pipeline stages through a DEPTH-entry in-order buffer with valid/ready handshakes on both sides. It keeps the legacy `stall` freeze and `refresh` flush semantics, and adds occupancy reporting and optional payload zeroing. It is used between EX/EC-style stages where the memory side can back-pressure.

---
 rtl/pipe_seg_buf.sv | 98 +++++++++
 tb/tb_pipe_seg_buf.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_seg_buf.sv
// rtl/pipe_seg_buf.sv - elastic in-order segment buffer between two pipeline stages
//
// Carries an opaque DW-bit payload through a DEPTH-entry FIFO with valid/ready
// on both sides, plus stall (freeze) and refresh (flush) controls.
//
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   stall                freeze: no push, no pop, state held
//   refresh              synchronous flush of all entries
//   in_valid/in_data     upstream payload, accepted when in_ready
//   in_ready             buffer can accept this cycle
//   out_valid/out_data   head entry
//   out_ready            downstream consumes the head
//   count                number of valid entries (0..DEPTH)
module pipe_seg_buf #(
  parameter int DW = 128,
  parameter int DEPTH = 2,
  parameter bit CLR_DATA = 1'b1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          stall,
  input  logic          refresh,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count_q;
  logic          push;
  logic          pop;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // in_ready looks only at registered occupancy: a pop while full frees the
  // slot next cycle, which keeps out_ready off the upstream ready path.
  assign in_ready  = !stall && (count_q < FULL_CNT);
  assign out_valid = (count_q != '0);
  assign out_data  = mem[rd_ptr];
  assign count     = count_q;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready && !stall;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count_q <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (refresh) begin
      // Flush wins over stall and any concurrent push/pop.
      count_q <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      if (CLR_DATA) begin
        for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end
    end else begin
      // push and pop never target the same entry: push needs count<DEPTH and
      // pop needs count>0, so wr_ptr != rd_ptr whenever both fire.
      if (pop) begin
        if (CLR_DATA) mem[rd_ptr] <= '0;
        rd_ptr <= next_ptr(rd_ptr);
      end
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (push && !pop) count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      assert (count_q <= FULL_CNT);
      assert (!(push && (count_q == FULL_CNT)));
      assert (!(pop && (count_q == '0)));
    end
  end

endmodule

// File: tb/tb_pipe_seg_buf.sv
// tb/tb_pipe_seg_buf.sv - self-checking bench for pipe_seg_buf
//
// Instance a: DW=128 DEPTH=2 CLR_DATA=1 (directed tests).
// Instances b (DEPTH=2, CLR_DATA=0), c (DEPTH=3), d (DEPTH=1) share one set of
// inputs and are checked against per-instance queue models.
module tb_pipe_seg_buf;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn = 1'b0;

  logic         a_stall = 0, a_refresh = 0, a_in_valid = 0, a_out_ready = 0;
  logic [127:0] a_in_data = '0;
  logic         a_in_ready, a_out_valid;
  logic [127:0] a_out_data;
  logic [1:0]   a_count;

  logic         s_stall = 0, s_refresh = 0, s_in_valid = 0, s_out_ready = 0;
  logic [15:0]  s_in_data = '0;
  logic         b_in_ready, b_out_valid, c_in_ready, c_out_valid, d_in_ready, d_out_valid;
  logic [15:0]  b_out_data, c_out_data, d_out_data;
  logic [1:0]   b_count, c_count;
  logic [0:0]   d_count;

  pipe_seg_buf #(.DW(128), .DEPTH(2), .CLR_DATA(1'b1)) u_a (
    .clk(clk), .resetn(resetn), .stall(a_stall), .refresh(a_refresh),
    .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
    .out_valid(a_out_valid), .out_data(a_out_data), .out_ready(a_out_ready), .count(a_count));

  pipe_seg_buf #(.DW(16), .DEPTH(2), .CLR_DATA(1'b0)) u_b (
    .clk(clk), .resetn(resetn), .stall(s_stall), .refresh(s_refresh),
    .in_valid(s_in_valid), .in_data(s_in_data), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(s_out_ready), .count(b_count));

  pipe_seg_buf #(.DW(16), .DEPTH(3), .CLR_DATA(1'b1)) u_c (
    .clk(clk), .resetn(resetn), .stall(s_stall), .refresh(s_refresh),
    .in_valid(s_in_valid), .in_data(s_in_data), .in_ready(c_in_ready),
    .out_valid(c_out_valid), .out_data(c_out_data), .out_ready(s_out_ready), .count(c_count));

  pipe_seg_buf #(.DW(16), .DEPTH(1), .CLR_DATA(1'b1)) u_d (
    .clk(clk), .resetn(resetn), .stall(s_stall), .refresh(s_refresh),
    .in_valid(s_in_valid), .in_data(s_in_data), .in_ready(d_in_ready),
    .out_valid(d_out_valid), .out_data(d_out_data), .out_ready(s_out_ready), .count(d_count));

  // Uniform views of the four instances, indexed 0=a 1=b 2=c 3=d.
  logic         o_ir [4];
  logic         o_ov [4];
  logic [127:0] o_od [4];
  logic [3:0]   o_cnt [4];
  assign o_ir[0] = a_in_ready;  assign o_ov[0] = a_out_valid;
  assign o_od[0] = a_out_data;  assign o_cnt[0] = {2'b0, a_count};
  assign o_ir[1] = b_in_ready;  assign o_ov[1] = b_out_valid;
  assign o_od[1] = {112'b0, b_out_data};  assign o_cnt[1] = {2'b0, b_count};
  assign o_ir[2] = c_in_ready;  assign o_ov[2] = c_out_valid;
  assign o_od[2] = {112'b0, c_out_data};  assign o_cnt[2] = {2'b0, c_count};
  assign o_ir[3] = d_in_ready;  assign o_ov[3] = d_out_valid;
  assign o_od[3] = {112'b0, d_out_data};  assign o_cnt[3] = {3'b0, d_count};

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: each buffer is simply an ordered queue of at most DEPTH items.
  logic [127:0] mq [4][$];

  function automatic int dep(int i);
    case (i)
      2: return 3;
      3: return 1;
      default: return 2;
    endcase
  endfunction

  function automatic logic [3:0] e_cnt(int i);
    return 4'(mq[i].size());
  endfunction

  function automatic logic e_ir(int i);
    logic st;
    st = (i == 0) ? a_stall : s_stall;
    return !st && (mq[i].size() < dep(i));
  endfunction

  function automatic logic e_ov(int i);
    return mq[i].size() != 0;
  endfunction

  function automatic logic [127:0] e_od(int i);
    return (mq[i].size() != 0) ? mq[i][0] : 128'h0;
  endfunction

  // Advance one clock and apply the transfer rules to every model.
  task automatic step();
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      logic st, rf, iv, ordy;
      logic [127:0] id;
      int n;
      if (i == 0) begin
        st = a_stall; rf = a_refresh; iv = a_in_valid; ordy = a_out_ready; id = a_in_data;
      end else begin
        st = s_stall; rf = s_refresh; iv = s_in_valid; ordy = s_out_ready; id = {112'b0, s_in_data};
      end
      n = mq[i].size();
      if (!resetn || rf) mq[i].delete();
      else if (!st) begin
        if (n > 0 && ordy) void'(mq[i].pop_front());
        if (iv && n < dep(i)) mq[i].push_back(id);
      end
    end
    #2;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    step();
    step();
    resetn = 1'b1;
    #1;
    n_chk++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b exp 0", a_out_valid); end
    n_chk++; if (a_out_data !== 128'h0) begin n_fail++; $display("FAIL reset_out_data: got %h exp 0", a_out_data); end
    n_chk++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b exp 1", a_in_ready); end
    n_chk++; if (a_count !== 2'd0) begin n_fail++; $display("FAIL reset_count: got %0d exp 0", a_count); end
    for (int i = 1; i < 4; i++) begin
      n_chk++; if (o_ir[i] !== 1'b1 || o_cnt[i] !== 4'd0) begin
        n_fail++; $display("FAIL reset_grp[%0d]: in_ready %b count %0d exp 1/0", i, o_ir[i], o_cnt[i]);
      end
    end
  endtask

  task automatic test_streaming();
    logic [127:0] vals [3];
    vals[0] = 128'h11; vals[1] = 128'h22; vals[2] = 128'h33;
    a_out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a_in_valid = 1'b1;
      a_in_data  = vals[k];
      step();
      n_chk++; if (a_out_data !== vals[k] || a_out_valid !== 1'b1) begin
        n_fail++; $display("FAIL stream_data[%0d]: got %h/%b exp %h/1", k, a_out_data, a_out_valid, vals[k]);
      end
      n_chk++; if (a_count !== 2'd1) begin n_fail++; $display("FAIL stream_count[%0d]: got %0d exp 1", k, a_count); end
    end
    a_in_valid = 1'b0;
    step();
    n_chk++; if (a_count !== 2'd0 || a_out_data !== 128'h0) begin
      n_fail++; $display("FAIL stream_drain: count %0d data %h exp 0/0", a_count, a_out_data);
    end
  endtask

  task automatic test_back_pressure();
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 128'hA; step();
    a_in_data = 128'hB; step();
    n_chk++; if (a_count !== 2'd2 || a_in_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_full: count %0d in_ready %b exp 2/0", a_count, a_in_ready);
    end
    a_in_data = 128'hC; step();
    n_chk++; if (a_count !== 2'd2 || a_out_data !== 128'hA) begin
      n_fail++; $display("FAIL bp_drop: count %0d head %h exp 2/a", a_count, a_out_data);
    end
    a_in_valid = 1'b0; a_out_ready = 1'b1; step();
    n_chk++; if (a_out_data !== 128'hB || a_in_ready !== 1'b1 || a_count !== 2'd1) begin
      n_fail++; $display("FAIL bp_pop1: head %h in_ready %b count %0d exp b/1/1", a_out_data, a_in_ready, a_count);
    end
    step();
    n_chk++; if (a_count !== 2'd0 || a_out_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_pop2: count %0d out_valid %b exp 0/0", a_count, a_out_valid);
    end
  endtask

  task automatic test_stall();
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 128'h5A; step();
    a_stall = 1'b1; a_out_ready = 1'b1; a_in_data = 128'h99;
    #1;
    n_chk++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready: got %b exp 0", a_in_ready); end
    for (int k = 0; k < 3; k++) begin
      step();
      n_chk++; if (a_count !== 2'd1 || a_out_data !== 128'h5A || a_in_ready !== 1'b0) begin
        n_fail++; $display("FAIL stall_hold[%0d]: count %0d head %h in_ready %b exp 1/5a/0", k, a_count, a_out_data, a_in_ready);
      end
    end
    a_stall = 1'b0; a_in_valid = 1'b0;
    step();
    n_chk++; if (a_count !== 2'd0 || a_out_valid !== 1'b0) begin
      n_fail++; $display("FAIL stall_release: count %0d out_valid %b exp 0/0", a_count, a_out_valid);
    end
  endtask

  task automatic test_refresh();
    a_out_ready = 1'b0; a_in_valid = 1'b1;
    a_in_data = 128'h1; step();
    a_in_data = 128'h2; step();
    a_refresh = 1'b1; a_in_data = 128'h77; a_out_ready = 1'b1;
    step();
    a_refresh = 1'b0; a_in_valid = 1'b0;
    n_chk++; if (a_count !== 2'd0 || a_out_valid !== 1'b0 || a_out_data !== 128'h0) begin
      n_fail++; $display("FAIL refresh_a: count %0d valid %b data %h exp 0/0/0", a_count, a_out_valid, a_out_data);
    end
    step();
    n_chk++; if (a_count !== 2'd0 || a_out_data !== 128'h0) begin
      n_fail++; $display("FAIL refresh_a_absent: count %0d data %h exp 0/0", a_count, a_out_data);
    end
    // Same on the shared group; b keeps stale data, c must read zero.
    s_out_ready = 1'b0; s_in_valid = 1'b1;
    s_in_data = 16'h0101; step();
    s_in_data = 16'h0202; step();
    s_refresh = 1'b1; s_in_data = 16'h0303; s_out_ready = 1'b1;
    step();
    s_refresh = 1'b0; s_in_valid = 1'b0;
    n_chk++; if (b_count !== 2'd0 || b_out_valid !== 1'b0) begin
      n_fail++; $display("FAIL refresh_b: count %0d valid %b exp 0/0", b_count, b_out_valid);
    end
    n_chk++; if (c_count !== 2'd0 || c_out_data !== 16'h0) begin
      n_fail++; $display("FAIL refresh_c: count %0d data %h exp 0/0", c_count, c_out_data);
    end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 300; cyc++) begin
      s_in_valid  = ($urandom_range(0, 3) != 0);
      s_in_data   = 16'($urandom);
      s_out_ready = ($urandom_range(0, 1) != 0);
      s_stall     = ($urandom_range(0, 9) == 0);
      s_refresh   = ($urandom_range(0, 39) == 0);
      resetn      = (cyc != 150);
      #1;
      for (int i = 1; i < 4; i++) begin
        n_chk++; if (o_ir[i] !== e_ir(i)) begin
          n_fail++; $display("FAIL rand_in_ready[%0d] cyc %0d: got %b exp %b", i, cyc, o_ir[i], e_ir(i));
        end
        n_chk++; if (o_ov[i] !== e_ov(i) || o_cnt[i] !== e_cnt(i)) begin
          n_fail++; $display("FAIL rand_occ[%0d] cyc %0d: valid %b count %0d exp %b/%0d", i, cyc, o_ov[i], o_cnt[i], e_ov(i), e_cnt(i));
        end
        if (e_ov(i) || i != 1) begin
          n_chk++; if (o_od[i] !== e_od(i)) begin
            n_fail++; $display("FAIL rand_data[%0d] cyc %0d: got %h exp %h", i, cyc, o_od[i][15:0], e_od(i) & 128'hffff);
          end
        end
      end
      step();
    end
    resetn = 1'b1; s_stall = 1'b0; s_refresh = 1'b0;
  endtask

  task automatic test_depth1_rate();
    int pushes_c, pushes_d;
    pushes_c = 0; pushes_d = 0;
    resetn = 1'b0; s_in_valid = 1'b0; step();
    resetn = 1'b1; s_in_valid = 1'b1; s_out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      s_in_data = 16'(16'h0100 + k);
      #1;
      if (d_in_ready) pushes_d++;
      if (c_in_ready) pushes_c++;
      n_chk++; if (d_in_ready !== (k % 2 == 0) || o_od[3] !== e_od(3)) begin
        n_fail++; $display("FAIL d1_cycle[%0d]: in_ready %b data %h exp %b/%h", k, d_in_ready, d_out_data, (k % 2 == 0), e_od(3) & 128'hffff);
      end
      step();
    end
    s_in_valid = 1'b0;
    n_chk++; if (pushes_d != 5) begin n_fail++; $display("FAIL d1_rate: got %0d transfers exp 5", pushes_d); end
    n_chk++; if (pushes_c != 10) begin n_fail++; $display("FAIL d3_rate: got %0d transfers exp 10", pushes_c); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_back_pressure();
    test_stall();
    test_refresh();
    test_random();
    test_depth1_rate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
